// File: rtl/rv32i_fetch.sv
// rv32i_fetch: instruction fetch stage.
// Owns the PC, issues in-order word requests under a credit limit, tags each response with its
// PC and buffers it for decode. A branch redirect flushes buffered entries and discards
// responses that are still in flight.
module rv32i_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        fetch_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;

    logic [31:0] tag_q        [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];

    logic [SW-1:0] in_use;
    logic          xfer;
    logic          keep;
    logic          pop;

    // Every buffered entry and every in-flight request (including ones to be discarded)
    // holds a credit, so a response can never find the buffer full.
    assign in_use    = SW'(outstanding_q) + SW'(count_q);
    assign imem_req  = !reset && !branch_taken && (in_use < SW'(DEPTH));
    assign imem_addr = pc_q;
    assign xfer      = imem_req && imem_gnt;
    assign keep      = imem_rvalid && (discard_q == '0);
    assign pop       = (count_q != '0) && !fetch_stall;

    assign if_valid = (count_q != '0);
    assign if_pc    = fifo_pc_q[rd_ptr_q];
    assign if_instr = fifo_instr_q[rd_ptr_q];

    // Next-state for PC, credit counters and queue pointers; redirect overrides all.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(xfer) - CW'(imem_rvalid);
        discard_d     = discard_q;
        count_d       = count_q + CW'(keep) - CW'(pop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;

        if (xfer) begin
            pc_d         = pc_q + 32'd4;
            tag_wr_ptr_d = tag_wr_ptr_q + AW'(1);
        end
        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if (keep) begin
            tag_rd_ptr_d = tag_rd_ptr_q + AW'(1);
            wr_ptr_d     = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (branch_taken) begin
            pc_d         = {branch_target[31:2], 2'b00};
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            tag_wr_ptr_d = '0;
            tag_rd_ptr_d = '0;
            // Everything still in flight after this cycle belongs to the wrong path.
            discard_d    = outstanding_d;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
        end
    end

    // PC-tag queue and instruction buffer storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]        <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            if (xfer) begin
                tag_q[tag_wr_ptr_q] <= pc_q;
            end
            if (keep) begin
                fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_ptr_q];
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the memory broke the protocol.
    rvalid_without_request: assert property (
        @(posedge clk) disable iff (reset) !(imem_rvalid && (outstanding_q == '0))
    ) else $error("rv32i_fetch: imem_rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_rv32i_fetch.sv
// Testbench for rv32i_fetch: random memory timing, stalls and redirects checked against a
// program-order reference model built from queues.
module tb_rv32i_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    rv32i_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_stall   (fetch_stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory side: requests accepted but not yet answered, in order.
    logic [31:0] pend_addr [$];
    bit          pend_wrong[$];
    int          pend_wait [$];
    // Decode side: PCs whose instruction should be waiting for decode, in program order.
    logic [31:0] buf_pc [$];
    logic [31:0] issue_pc;

    int stall_pct;
    int gnt_pct;
    int rv_pct;
    int bt_pct;
    int lat_max;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(4))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0203;
            2:       return 32'hFFFF_FFF6;
            3:       return {16'h0000, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        fetch_stall   = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        #1;
        check_eq("reset_imem_req", {31'b0, imem_req}, 32'd0);
        check_eq("reset_if_valid", {31'b0, if_valid}, 32'd0);
        check_eq("reset_if_pc", if_pc, 32'd0);
        check_eq("reset_if_instr", if_instr, 32'd0);
        pend_addr.delete();
        pend_wrong.delete();
        pend_wait.delete();
        buf_pc.delete();
        issue_pc = RESET_PC;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare, then advance the model.
    task automatic cycle(input bit bt, input logic [31:0] tgt);
        bit          exp_req;
        bit          had_buf;
        logic [31:0] a;
        bit          w;
        @(negedge clk);
        fetch_stall   = ($urandom_range(99) < stall_pct);
        imem_gnt      = ($urandom_range(99) < gnt_pct);
        branch_taken  = bt;
        branch_target = tgt;
        imem_rvalid   = 1'b0;
        if (pend_addr.size() > 0) begin
            if (pend_wait[0] == 0 && $urandom_range(99) < rv_pct) imem_rvalid = 1'b1;
        end
        imem_rdata = imem_rvalid ? mem_word(pend_addr[0]) : $urandom;
        #1;
        exp_req = !bt && ((pend_addr.size() + buf_pc.size()) < DEPTH);
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check_eq("imem_addr", imem_addr, issue_pc);
        had_buf = (buf_pc.size() > 0);
        check_eq("if_valid", {31'b0, if_valid}, {31'b0, had_buf});
        if (had_buf) begin
            check_eq("if_pc", if_pc, buf_pc[0]);
            check_eq("if_instr", if_instr, mem_word(buf_pc[0]));
        end

        for (int i = 0; i < pend_wait.size(); i++) begin
            if (pend_wait[i] > 0) pend_wait[i] = pend_wait[i] - 1;
        end
        if (imem_rvalid) begin
            a = pend_addr.pop_front();
            w = pend_wrong.pop_front();
            void'(pend_wait.pop_front());
        end
        if (bt) begin
            for (int i = 0; i < pend_wrong.size(); i++) pend_wrong[i] = 1'b1;
            buf_pc.delete();
            issue_pc = {tgt[31:2], 2'b00};
        end else begin
            if (had_buf && !fetch_stall) void'(buf_pc.pop_front());
            if (imem_rvalid && !w) buf_pc.push_back(a);
            if (exp_req && imem_gnt) begin
                pend_addr.push_back(issue_pc);
                pend_wrong.push_back(1'b0);
                pend_wait.push_back($urandom_range(lat_max));
                issue_pc = issue_pc + 32'd4;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            cycle(($urandom_range(99) < bt_pct), pick_target());
        end
    endtask

    task automatic set_knobs(input int s, input int g, input int r, input int b, input int l);
        stall_pct = s;
        gnt_pct   = g;
        rv_pct    = r;
        bt_pct    = b;
        lat_max   = l;
    endtask

    initial begin
        reset = 1'b1;
        set_knobs(0, 100, 100, 0, 0);
        do_reset();

        // Streaming, single-cycle memory, no stall.
        run_cycles(20);

        // Decode stalled: credit runs out, then release.
        set_knobs(100, 100, 100, 0, 0);
        run_cycles(10);
        set_knobs(0, 100, 100, 0, 0);
        run_cycles(10);

        // Redirects with requests in flight, including an unaligned target.
        set_knobs(0, 100, 100, 0, 2);
        run_cycles(3);
        cycle(1'b1, 32'h0000_0100);
        run_cycles(8);
        cycle(1'b1, 32'h0000_0203);
        run_cycles(8);
        cycle(1'b1, 32'h0000_0400);
        cycle(1'b1, 32'h0000_0500);
        run_cycles(8);

        // Grant withheld, then a redirect during the wait.
        set_knobs(0, 0, 100, 0, 1);
        run_cycles(4);
        cycle(1'b1, 32'h0000_0300);
        run_cycles(2);
        set_knobs(0, 100, 100, 0, 1);
        run_cycles(6);

        // Sequential fetch across the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF8);
        run_cycles(12);

        // Reset in the middle of traffic.
        do_reset();
        run_cycles(6);

        // Fully random traffic.
        set_knobs(30, 60, 70, 5, 3);
        run_cycles(3000);
        set_knobs(70, 90, 90, 10, 1);
        run_cycles(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
